// File: rtl/shift_rotate_unit.sv
// shift_rotate_unit: multi-mode shift/rotate register with parallel load and clear.
// Shift and rotate ops advance one bit per clock under a start/busy/done handshake.
module shift_rotate_unit #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned AW    = $clog2(WIDTH) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [AW-1:0]    amount,
   input  logic [WIDTH-1:0] data_in,
   input  logic             serial_in,
   output logic [WIDTH-1:0] q,
   output logic             serial_out,
   output logic             busy,
   output logic             done
);

   typedef enum logic [2:0] {
      OP_NOP   = 3'b000,
      OP_LOAD  = 3'b001,
      OP_ROL   = 3'b010,
      OP_ROR   = 3'b011,
      OP_LSL   = 3'b100,
      OP_LSR   = 3'b101,
      OP_ASR   = 3'b110,
      OP_CLEAR = 3'b111
   } op_e;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   state_e           state, state_n;
   op_e              op_q, op_n;
   op_e              op_in;
   logic [AW-1:0]    cnt, cnt_n;
   logic [AW-1:0]    amount_clamped;
   logic             is_shift_op;
   logic [WIDTH-1:0] q_n;
   logic             serial_out_n;
   logic             busy_n;
   logic             done_n;

   assign op_in = op_e'(op);

   // Decode request: which ops need multi-step execution, and clamp the step count to WIDTH
   always_comb begin
      is_shift_op = 1'b0;
      case (op_in)
         OP_ROL, OP_ROR, OP_LSL, OP_LSR, OP_ASR: is_shift_op = 1'b1;
         default:                                is_shift_op = 1'b0;
      endcase
      amount_clamped = (amount > AW'(WIDTH)) ? AW'(WIDTH) : amount;
   end

   // State register plus all registered outputs; reset wins over any activity
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         op_q       <= OP_NOP;
         cnt        <= '0;
         q          <= '0;
         serial_out <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_n;
         op_q       <= op_n;
         cnt        <= cnt_n;
         q          <= q_n;
         serial_out <= serial_out_n;
         busy       <= busy_n;
         done       <= done_n;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_n      = state;
      op_n         = op_q;
      cnt_n        = cnt;
      q_n          = q;
      serial_out_n = serial_out;
      busy_n       = busy;
      done_n       = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               if (is_shift_op && (amount != '0)) begin
                  op_n    = op_in;
                  cnt_n   = amount_clamped;
                  busy_n  = 1'b1;
                  state_n = SHIFT;
               end else begin
                  // Zero-latency ops: NOP and zero-amount shifts leave q alone
                  case (op_in)
                     OP_LOAD:  q_n = data_in;
                     OP_CLEAR: q_n = '0;
                     default:  q_n = q;
                  endcase
                  done_n = 1'b1;
               end
            end
         end

         SHIFT: begin
            case (op_q)
               OP_ROL: begin
                  q_n          = {q[WIDTH-2:0], q[WIDTH-1]};
                  serial_out_n = q[WIDTH-1];
               end
               OP_ROR: begin
                  q_n          = {q[0], q[WIDTH-1:1]};
                  serial_out_n = q[0];
               end
               OP_LSL: begin
                  q_n          = {q[WIDTH-2:0], serial_in};
                  serial_out_n = q[WIDTH-1];
               end
               OP_LSR: begin
                  q_n          = {serial_in, q[WIDTH-1:1]};
                  serial_out_n = q[0];
               end
               OP_ASR: begin
                  q_n          = {q[WIDTH-1], q[WIDTH-1:1]};
                  serial_out_n = q[0];
               end
               default: begin
                  q_n          = q;
                  serial_out_n = serial_out;
               end
            endcase
            cnt_n = cnt - AW'(1);
            if (cnt == AW'(1)) begin
               state_n = IDLE;
               busy_n  = 1'b0;
               done_n  = 1'b1;
            end
         end

         default: state_n = IDLE;
      endcase
   end

endmodule

// File: doc/shift_rotate_unit.md
Name: shift_rotate_unit

Overview:
Parametrised multi-mode shift/rotate register with parallel load, clear, and multi-step shift by a programmable amount.
A shift/rotate runs one bit position per clock under a start/busy/done handshake.
Used as the general shift datapath element for lab datapaths and for serial-link framing.
Supersedes fixed 4-bit shift registers.

Parameters:
WIDTH, 8, register width in bits (>= 2)
AW, $clog2(WIDTH)+1, width of the amount port (derived; do not override)

Ports:
clock  input  1  system clock, rising-edge
reset  input  1  synchronous, active-high reset
start  input  1  request; accepted only when idle (busy=0)
op  input  3  operation code, sampled on the accepted start
amount  input  AW  number of bit steps for shift/rotate ops, sampled on the accepted start
data_in  input  WIDTH  parallel load value
serial_in  input  1  fill bit for logical shifts, sampled live on every step
q  output  WIDTH  register contents
serial_out  output  1  bit most recently shifted/rotated out
busy  output  1  multi-step operation in progress
done  output  1  one-cycle completion pulse

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clock.
- Reset values: q=0, serial_out=0, busy=0, done=0, state=IDLE, step counter=0. Reset has priority over everything, including mid-operation.
- Op codes:
  - 000 NOP
  - 001 LOAD (q<=data_in)
  - 010 ROL
  - 011 ROR
  - 100 LSL (fill LSB with serial_in)
  - 101 LSR (fill MSB with serial_in)
  - 110 ASR (replicate MSB)
  - 111 CLEAR (q<=0)
- States: IDLE, SHIFT.
- IDLE, start=1, op in {NOP, LOAD, CLEAR}, or any shift op with amount=0:
  - Action applied at the accepting edge; NOP and amount=0 leave q unchanged.
  - done=1 for exactly the following cycle; busy stays 0; serial_out unchanged.
- IDLE, start=1, shift op, amount>0:
  - At the accepting edge E0: latch op; counter<=min(amount, WIDTH), so amounts above WIDTH clamp to WIDTH; busy<=1; state<=SHIFT; q unchanged.
- SHIFT, at each edge:
  - Perform one 1-bit step of the latched op and decrement the counter.
  - serial_out<=the exiting bit: MSB for ROL/LSL, LSB for ROR/LSR/ASR. For rotates this is the wrapped bit.
  - On the step where the counter goes 1->0: state<=IDLE, busy<=0, done<=1.
- Latency: N-step op accepted at E0 completes at edge E_N. busy=1 for N cycles; done is high in the cycle after E_N, coincident with busy falling.
- While busy=1: start, op, amount and data_in are ignored, with no queueing.
- done is a one-cycle pulse and never stays high for two consecutive cycles unless a new 0-latency op is accepted on the cycle done is high.
- Idle with start=0: q, serial_out hold; done=0.
- No combinational path from inputs to outputs; all outputs registered.

Test Plan (WIDTH=8):
1. LOAD: data_in=8'hA5, op=001, start pulse -> q=8'hA5 after that edge; done=1 one cycle; busy never 1.
2. ROL by 3 from q=8'hA5 -> q sequence 4B, 96, 2D. busy=1 for 3 cycles; done pulses with busy falling; final q=8'h2D, serial_out=1.
3. ASR by 2 from q=8'h90 -> q=8'hE4, serial_out=0. Then LSR by 1 with serial_in=1 -> q=8'hF2.
4. LSL with amount=10 (clamped to 8), serial_in held 1, from q=8'h00 -> exactly 8 steps; q=8'hFF; done one cycle after the 8th step edge.
5. ROR by 4 from 8'h3C; start with op=LOAD, data_in=8'h11 raised mid-operation -> ignored; final q=8'hC3. Repeat, asserting reset after 2 steps -> next cycle q=0, busy=0, done=0, and a new start is accepted.
6. ROR with amount=0 on q=8'h5A -> q stays 8'h5A; done=1 one cycle; busy never 1. CLEAR -> q=8'h00 with done pulse.
